hex_word_entry: RTL and testbench

- Input-side counterpart of the eight-digit hex display path: builds a 32-bit word from board switches and push-keys, one hex nibble at a time.
- Drives the live edit buffer to the `Digits` display block, so the operator sees digits as they are entered.
- Hands the committed word, for example an instruction to load into the CPU demo, to a consumer via a valid/ready handshake.
- Replaces the hard-coded display constant in demo tops.

---
 rtl/hex_word_entry.sv | 155 +++++++++++++++
 tb/tb_hex_word_entry.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_word_entry.sv
// Hex word entry: builds a 32-bit word nibble by nibble from switches and debounced push-keys,
// then offers it to a consumer over valid/ready. Optional cursor blink: HEX_WORD_ENTRY_BLINK_EN.
module hex_word_entry #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned BLINK_CYCLES    = 12500000
) (
    input  logic        src_clk,
    input  logic        src_rst_n,
    input  logic [3:0]  sw,
    input  logic        key_enter_n,
    input  logic        key_back_n,
    input  logic        key_commit_n,
    output logic [31:0] disp,
    output logic [3:0]  digit_cnt,
    output logic [7:0]  blank_mask,
    output logic [7:0]  blink_mask,
    output logic [31:0] word,
    output logic        word_valid,
    input  logic        word_ready
);

    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES + 1);

    if (DEBOUNCE_CYCLES == 0 || BLINK_CYCLES == 0) begin : g_bad_params
        $error("hex_word_entry: DEBOUNCE_CYCLES and BLINK_CYCLES must be non-zero");
    end

    typedef enum logic {StEdit, StHold} state_e;

    logic [3:0]    sw_meta, sw_sync;
    logic [2:0]    key_meta, key_sync, key_deb, key_evt;  // {commit, back, enter}
    logic [DW-1:0] db_cnt [3];

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            key_meta <= '1;
            key_sync <= '1;
            key_deb  <= '1;
            key_evt  <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            key_meta <= {key_commit_n, key_back_n, key_enter_n};
            key_sync <= key_meta;
            for (int i = 0; i < 3; i++) begin
                key_evt[i] <= 1'b0;
                if (key_sync[i] == key_deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                    db_cnt[i]  <= '0;
                    key_deb[i] <= key_sync[i];
                    // Only the released->pressed flip is an event
                    key_evt[i] <= key_deb[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    logic evt_enter, evt_back, evt_commit;
    assign evt_enter  = key_evt[0];
    assign evt_back   = key_evt[1];
    assign evt_commit = key_evt[2];

    state_e      state;
    logic [31:0] disp_d;
    logic [3:0]  cnt_d;
    logic [7:0]  blank_d;
    logic        commit_go;

    always_comb begin
        disp_d    = disp;
        cnt_d     = digit_cnt;
        commit_go = 1'b0;
        // Commit claims the cycle even in HOLD, where it is simply discarded
        if (evt_commit) begin
            commit_go = (state == StEdit);
        end else if (evt_back) begin
            if (digit_cnt != 4'd0) begin
                disp_d = {4'h0, disp[31:4]};
                cnt_d  = digit_cnt - 4'd1;
            end
        end else if (evt_enter) begin
            disp_d = {disp[27:0], sw_sync};
            if (digit_cnt != 4'd8) cnt_d = digit_cnt + 4'd1;
        end
        if (commit_go) begin
            disp_d = '0;
            cnt_d  = '0;
        end
        for (int i = 0; i < 8; i++) blank_d[i] = (4'(i) >= cnt_d);
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state      <= StEdit;
            disp       <= '0;
            digit_cnt  <= '0;
            blank_mask <= 8'hFF;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            disp       <= disp_d;
            digit_cnt  <= cnt_d;
            blank_mask <= blank_d;
            case (state)
                StEdit: begin
                    if (commit_go) begin
                        word       <= disp;
                        word_valid <= 1'b1;
                        state      <= StHold;
                    end
                end
                StHold: begin
                    if (word_ready) begin
                        word_valid <= 1'b0;
                        state      <= StEdit;
                    end
                end
                default: state <= StEdit;
            endcase
        end
    end

`ifdef HEX_WORD_ENTRY_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_CYCLES + 1);

    logic [BW-1:0] blink_cnt;
    logic          phase;

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (evt_enter || evt_back) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
            blink_cnt <= '0;
            phase     <= ~phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_mask = (phase && digit_cnt != 4'd8) ? (8'h01 << digit_cnt[2:0]) : 8'h00;
`else
    assign blink_mask = 8'h00;
`endif

endmodule

// File: tb/tb_hex_word_entry.sv
// Directed bench for hex_word_entry: a behavioural model pushes expected states into a
// scoreboard queue as keys are driven; they are popped and compared once the key has settled.
module tb_hex_word_entry;

    localparam int unsigned DEB = 4;
    localparam int unsigned BLK = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  sw;
    logic [2:0]  kn;  // {commit, back, enter}, active low
    logic [31:0] disp, word;
    logic [3:0]  digit_cnt;
    logic [7:0]  blank_mask, blink_mask;
    logic        word_valid, word_ready;

    hex_word_entry #(.DEBOUNCE_CYCLES(DEB), .BLINK_CYCLES(BLK)) dut (
        .src_clk     (clk),
        .src_rst_n   (rst_n),
        .sw          (sw),
        .key_enter_n (kn[0]),
        .key_back_n  (kn[1]),
        .key_commit_n(kn[2]),
        .disp        (disp),
        .digit_cnt   (digit_cnt),
        .blank_mask  (blank_mask),
        .blink_mask  (blink_mask),
        .word        (word),
        .word_valid  (word_valid),
        .word_ready  (word_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] disp;
        logic [3:0]  cnt;
        logic [31:0] word;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] m_disp;
    logic [3:0]  m_cnt;
    logic [31:0] m_word;
    logic        m_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_blank(input logic [3:0] c);
        logic [15:0] t;
        t = (16'd1 << c) - 16'd1;
        return ~t[7:0];
    endfunction

    task automatic m_reset();
        m_disp = '0; m_cnt = '0; m_word = '0; m_valid = 1'b0;
    endtask

    task automatic m_enter(input logic [3:0] nib);
        m_disp = {m_disp[27:0], nib};
        if (m_cnt < 4'd8) m_cnt = m_cnt + 4'd1;
    endtask

    task automatic m_back();
        if (m_cnt != 4'd0) begin
            m_disp = m_disp >> 4;
            m_cnt  = m_cnt - 4'd1;
        end
    endtask

    task automatic m_commit();
        if (!m_valid) begin
            m_word = m_disp; m_valid = 1'b1; m_disp = '0; m_cnt = '0;
        end
    endtask

    task automatic push();
        exp_t e;
        e.disp = m_disp; e.cnt = m_cnt; e.word = m_word; e.valid = m_valid;
        sb.push_back(e);
    endtask

    task automatic check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_disp"},  disp, e.disp);
            chk({tag, "_cnt"},   32'(digit_cnt), 32'(e.cnt));
            chk({tag, "_blank"}, 32'(blank_mask), 32'(exp_blank(e.cnt)));
            chk({tag, "_word"},  word, e.word);
            chk({tag, "_valid"}, 32'(word_valid), 32'(e.valid));
        end
    endtask

    task automatic press(input logic [2:0] which);
        @(negedge clk);
        kn = kn & ~which;
        repeat (12) @(negedge clk);
        kn = 3'b111;
        repeat (12) @(negedge clk);
    endtask

    task automatic do_enter(input logic [3:0] nib, input string tag);
        sw = nib;
        repeat (3) @(negedge clk);
        m_enter(nib); push();
        press(3'b001);
        check(tag);
    endtask

    task automatic do_back(input string tag);
        m_back(); push();
        press(3'b010);
        check(tag);
    endtask

    logic [7:0] bs [32];
    int         lat, f;
    logic [7:0] a, b, expv;

    initial begin
        rst_n = 1'b0; sw = 4'h0; kn = 3'b111; word_ready = 1'b0;
        m_reset();
        repeat (3) @(negedge clk);
        push(); check("reset");
        chk("reset_blink", 32'(blink_mask), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // First digit also measures event-to-update latency
        sw = 4'h0;
        repeat (3) @(negedge clk);
        m_enter(4'h0); push();
        kn[0] = 1'b0;
        lat = 0;
        while (digit_cnt == 4'd0 && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        chk("enter_latency", 32'(lat), 32'(DEB + 3));
        repeat (8) @(negedge clk);
        kn = 3'b111;
        repeat (12) @(negedge clk);
        check("e0");
        do_enter(4'h0, "e1"); do_enter(4'hC, "e2"); do_enter(4'h0, "e3");
        do_enter(4'h0, "e4"); do_enter(4'h1, "e5"); do_enter(4'h9, "e6");
        do_enter(4'h3, "e7");
        chk("disp_00C00193", disp, 32'h00C00193);

        // Commit with consumer stalled; a second commit is dropped
        m_commit(); push(); press(3'b100); check("commit");
        push(); press(3'b100); check("commit_again");
        @(negedge clk); word_ready = 1'b1;
        @(negedge clk); word_ready = 1'b0;
        m_valid = 1'b0; push(); check("handshake");

        // Bouncing enter key yields exactly one event
        sw = 4'h0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            kn[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            repeat (2) @(negedge clk);
        end
        m_enter(4'h0); push();
        kn[0] = 1'b0;
        repeat (12) @(negedge clk);
        kn = 3'b111;
        repeat (12) @(negedge clk);
        check("bounce");

        do_enter(4'hA, "eA"); do_enter(4'hB, "eB");
        chk("disp_0AB", disp, 32'h000000AB);
        do_back("b1"); do_back("b2"); do_enter(4'h5, "e5b");
        do_back("b3"); do_back("b4"); do_back("b_empty");

        // Cursor blink at digit_cnt = 3
        do_enter(4'h1, "c1"); do_enter(4'h2, "c2"); do_enter(4'h3, "c3");
        for (int i = 0; i < 32; i++) begin
            bs[i] = blink_mask;
            @(negedge clk);
        end
`ifdef HEX_WORD_ENTRY_BLINK_EN
        f = 0;
        for (int i = 31; i > 0; i--) if (bs[i] != bs[i-1]) f = i;
        a = bs[(f > 0) ? f - 1 : 0];
        b = bs[f];
        chk("blink_pair", 32'(a | b), 32'h08);
        chk("blink_edge_found", 32'(f > 0 && f < 9), 32'd1);
        for (int i = 0; i < 32; i++) begin
            if (i < f) expv = a;
            else expv = (((i - f) / 8) % 2 == 0) ? b : a;
            chk("blink_seq", 32'(bs[i]), 32'(expv));
        end
`else
        for (int i = 0; i < 32; i += 4) chk("blink_off", 32'(bs[i]), 32'h0);
`endif

        for (int n = 1; n <= 9; n++) do_enter(4'(n), "nine");
        chk("disp_23456789", disp, 32'h23456789);

        // Enter and commit in the same cycle: commit wins
        sw = 4'hF;
        repeat (3) @(negedge clk);
        m_commit(); push(); press(3'b101); check("enter_commit");
        chk("word_23456789", word, 32'h23456789);

        // Edit in HOLD, then reset mid-HOLD
        do_enter(4'h4, "hold_edit");
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        m_reset(); push(); check("reset_hold");
        chk("reset_hold_blink", 32'(blink_mask), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
